// File: rtl/lif_spike_encoder_if.sv
// lif_spike_encoder_if
//   Sample handshake between the velocity source and the LIF spike encoder.
//   sample_valid  source -> encoder  sample_x/sample_y hold a valid sample
//   sample_ready  encoder -> source  encoder accepts a sample on this edge
//   sample_x      source -> encoder  signed x velocity
//   sample_y      source -> encoder  signed y velocity
interface lif_spike_encoder_if #(
    parameter int DATA_W = 16
);
    logic                     sample_valid;
    logic                     sample_ready;
    logic signed [DATA_W-1:0] sample_x;
    logic signed [DATA_W-1:0] sample_y;

    modport master (
        output sample_valid,
        output sample_x,
        output sample_y,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_x,
        input  sample_y,
        output sample_ready
    );
endinterface

// File: rtl/lif_spike_encoder.sv
// lif_spike_encoder
//   Converts signed x/y velocity samples into four spike trains with leaky
//   integrate-and-fire membranes. Each spike is shaped into a PULSE_W-cycle
//   high pulse followed by at least GAP_W low cycles so the downstream
//   odometry block sees exactly one rising edge per spike.
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   enable        1 = accept samples, 0 = hold membranes
//   clear         zero membranes, pending counts, sat_flag; pulse lines to IDLE
//   threshold     unsigned firing threshold, 0 disables firing
//   leak_shift    per-sample leak v >>> leak_shift, 0 = no leak
//   smp           sample handshake (slave side)
//   spike_out     [0]=x+ [1]=y+ [2]=x- [3]=y-, registered
//   spike_total   wrapping count of emitted pulses on all lines
//   sat_flag      sticky, set when a membrane clamps
module lif_spike_encoder #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 20,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2,
    parameter int PEND_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [15:0]         threshold,
    input  logic [3:0]          leak_shift,
    lif_spike_encoder_if.slave  smp,
    output logic [3:0]          spike_out,
    output logic [15:0]         spike_total,
    output logic                sat_flag
);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} line_state_t;

    // Saturating narrowing of a one-bit-wide sum: returns {clamped, value}.
    function automatic logic [ACC_W:0] sat_acc(input logic signed [ACC_W:0] sum);
        logic clamped;
        logic [ACC_W-1:0] res;
        clamped = sum[ACC_W] ^ sum[ACC_W-1];
        if (clamped)
            res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            res = sum[ACC_W-1:0];
        return {clamped, res};
    endfunction

    // One membrane update: returns {clamped, fire_pos, fire_neg, v_next}.
    function automatic logic [ACC_W+2:0] membrane_step(
        input logic signed [ACC_W-1:0]  v,
        input logic signed [DATA_W-1:0] s,
        input logic [3:0]               sh,
        input logic [15:0]              thr
    );
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] b;
        logic signed [ACC_W-1:0] t;
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W:0]   sum;
        logic [ACC_W:0]          sat_res;
        logic                    pos;
        logic                    neg;
        a       = (sh != 4'd0) ? (v - (v >>> sh)) : v;
        sum     = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){s[DATA_W-1]}}, s};
        sat_res = sat_acc(sum);
        b       = sat_res[ACC_W-1:0];
        t       = {{(ACC_W-16){1'b0}}, thr};
        pos     = (thr != 16'd0) && (b >= t);
        neg     = (thr != 16'd0) && !pos && (b <= -t);
        // Residuals always fit: b-T with b>=T>0, b+T with b<=-T<0.
        r       = pos ? (b - t) : (neg ? (b + t) : b);
        return {sat_res[ACC_W], pos, neg, r};
    endfunction

    logic signed [ACC_W-1:0] v_x_q, v_y_q, v_x_d, v_y_d;
    logic [ACC_W+2:0]        step_x, step_y;
    logic                    xfer;
    logic                    all_room;
    logic                    sat_d;
    logic [3:0]              fire;
    logic [3:0]              start;
    logic [3:0]              spike_d;
    logic [2:0]              n_start;
    logic [15:0]             total_d;
    line_state_t             st_q[4], st_d[4];
    logic [7:0]              cnt_q[4], cnt_d[4];
    logic [PEND_W-1:0]       pend_q[4], pend_d[4];

    always_comb begin
        all_room = 1'b1;
        for (int i = 0; i < 4; i++)
            if (pend_q[i] == {PEND_W{1'b1}}) all_room = 1'b0;
    end

    assign smp.sample_ready = enable & ~clear & all_room;
    assign xfer             = smp.sample_valid & smp.sample_ready;

    always_comb begin
        step_x = membrane_step(v_x_q, smp.sample_x, leak_shift, threshold);
        step_y = membrane_step(v_y_q, smp.sample_y, leak_shift, threshold);
        fire   = xfer ? {step_y[ACC_W], step_x[ACC_W], step_y[ACC_W+1], step_x[ACC_W+1]}
                      : 4'b0000;
        v_x_d  = v_x_q;
        v_y_d  = v_y_q;
        sat_d  = sat_flag;
        if (clear) begin
            v_x_d = '0;
            v_y_d = '0;
            sat_d = 1'b0;
        end else if (xfer) begin
            v_x_d = step_x[ACC_W-1:0];
            v_y_d = step_y[ACC_W-1:0];
            sat_d = sat_flag | step_x[ACC_W+2] | step_y[ACC_W+2];
        end
    end

    // Pulse shaping per line. GAP falls straight into HIGH when another spike
    // is queued so back-to-back spikes repeat every PULSE_W+GAP_W cycles.
    always_comb begin
        n_start = 3'd0;
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            start[i] = 1'b0;
            if (clear) begin
                st_d[i]  = IDLE;
                cnt_d[i] = 8'd0;
            end else begin
                case (st_q[i])
                    IDLE: begin
                        if (pend_q[i] != '0) begin
                            st_d[i]  = HIGH;
                            cnt_d[i] = 8'd0;
                            start[i] = 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt_q[i] == 8'(PULSE_W - 1)) begin
                            st_d[i]  = GAP;
                            cnt_d[i] = 8'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    GAP: begin
                        if (cnt_q[i] == 8'(GAP_W - 1)) begin
                            cnt_d[i] = 8'd0;
                            if (pend_q[i] != '0) begin
                                st_d[i]  = HIGH;
                                start[i] = 1'b1;
                            end else begin
                                st_d[i]  = IDLE;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                    default: begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = 8'd0;
                    end
                endcase
            end
            spike_d[i] = (st_d[i] == HIGH);
            n_start    = n_start + {2'b00, start[i]};
            if (clear)
                pend_d[i] = '0;
            else begin
                case ({fire[i], start[i]})
                    2'b10:   pend_d[i] = pend_q[i] + {{(PEND_W-1){1'b0}}, 1'b1};
                    2'b01:   pend_d[i] = pend_q[i] - {{(PEND_W-1){1'b0}}, 1'b1};
                    default: pend_d[i] = pend_q[i];
                endcase
            end
        end
        total_d = spike_total + {13'd0, n_start};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_x_q       <= '0;
            v_y_q       <= '0;
            sat_flag    <= 1'b0;
            spike_out   <= 4'b0000;
            spike_total <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= IDLE;
                cnt_q[i]  <= 8'd0;
                pend_q[i] <= '0;
            end
        end else begin
            v_x_q       <= v_x_d;
            v_y_q       <= v_y_d;
            sat_flag    <= sat_d;
            spike_out   <= spike_d;
            spike_total <= total_d;
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: tb/tb_lif_spike_encoder.sv
// tb_lif_spike_encoder
//   Directed bench for lif_spike_encoder: a per-cycle vector table for the
//   basic firing/leak/clear behaviour, then hand-written sequences for
//   saturation, pending back-pressure and asynchronous reset mid-pulse.
module tb_lif_spike_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] threshold = 16'd0;
    logic [3:0]  leak_shift = 4'd0;
    logic [3:0]  spike_out;
    logic [15:0] spike_total;
    logic        sat_flag;

    lif_spike_encoder_if #(.DATA_W(16)) sif();

    lif_spike_encoder #(
        .DATA_W(16), .ACC_W(20), .PULSE_W(2), .GAP_W(2), .PEND_W(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .threshold   (threshold),
        .leak_shift  (leak_shift),
        .smp         (sif.slave),
        .spike_out   (spike_out),
        .spike_total (spike_total),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [3:0]  lk;
        logic        vld;
        logic [15:0] x;
        logic [15:0] y;
        logic        rdy;
        logic [3:0]  spk;
        logic [15:0] tot;
        logic        sat;
    } vec_t;

    vec_t tv[$];

    int n_total = 0;
    int n_pass  = 0;

    // line-0 pulse monitor state
    int cyc = 0;
    int rises = 0;
    int last_rise = -1;
    int min_int = 1000;
    int max_int = 0;
    int other_hi = 0;
    logic prev0 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        int d;
        @(posedge clk);
        #1;
        cyc++;
        if (spike_out[0] && !prev0) begin
            rises++;
            if (last_rise >= 0) begin
                d = cyc - last_rise;
                if (d < min_int) min_int = d;
                if (d > max_int) max_int = d;
            end
            last_rise = cyc;
        end
        prev0 = spike_out[0];
        if (spike_out[3:1] != 3'b000) other_hi++;
    endtask

    function automatic void add(input logic clr, input int lk, input logic vld, input int x,
                                input int y, input logic rdy, input int spk, input int tot,
                                input logic sat);
        vec_t r;
        r.clr = clr;
        r.lk  = 4'(lk);
        r.vld = vld;
        r.x   = 16'(x);
        r.y   = 16'(y);
        r.rdy = rdy;
        r.spk = 4'(spk);
        r.tot = 16'(tot);
        r.sat = sat;
        tv.push_back(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] base_total;
        logic [15:0] diff;
        int          acc;
        logic        got_full;

        sif.sample_valid = 1'b0;
        sif.sample_x     = 16'sd0;
        sif.sample_y     = 16'sd0;

        // T=10, no leak: three x=4 samples -> one x+ pulse, residual 2
        add(0,0,1,  4,  0, 1,0,0,0);
        add(0,0,1,  4,  0, 1,0,0,0);
        add(0,0,1,  4,  0, 1,0,0,0);
        add(0,0,0,  0,  0, 1,1,1,0);
        add(0,0,0,  0,  0, 1,1,1,0);
        add(0,0,0,  0,  0, 1,0,1,0);
        add(0,0,0,  0,  0, 1,0,1,0);
        add(0,0,0,  0,  0, 1,0,1,0);
        // residual 2 + 8 reaches threshold exactly
        add(0,0,1,  8,  0, 1,0,1,0);
        add(0,0,0,  0,  0, 1,1,2,0);
        add(0,0,0,  0,  0, 1,1,2,0);
        add(0,0,0,  0,  0, 1,0,2,0);
        add(0,0,0,  0,  0, 1,0,2,0);
        // y=-25 twice: two y- pulses with a 4-cycle period
        add(0,0,1,  0,-25, 1,0,2,0);
        add(0,0,1,  0,-25, 1,8,3,0);
        add(0,0,0,  0,  0, 1,8,3,0);
        add(0,0,0,  0,  0, 1,0,3,0);
        add(0,0,0,  0,  0, 1,0,3,0);
        add(0,0,0,  0,  0, 1,8,4,0);
        add(0,0,0,  0,  0, 1,8,4,0);
        add(0,0,0,  0,  0, 1,0,4,0);
        add(0,0,0,  0,  0, 1,0,4,0);
        // clear blocks the concurrent sample and zeroes membranes
        add(1,0,1,100,  0, 0,0,4,0);
        add(0,0,1,  8, -5, 1,0,4,0);
        // leak 1: v_x 8 -> 4; then 4+5=9 no fire, 9+1=10 fires
        add(0,1,1,  0,  0, 1,0,4,0);
        add(0,0,1,  5,  0, 1,0,4,0);
        add(0,0,1,  1,  0, 1,0,4,0);
        add(0,0,0,  0,  0, 1,1,5,0);
        add(0,0,0,  0,  0, 1,1,5,0);
        add(0,0,0,  0,  0, 1,0,5,0);
        add(0,0,0,  0,  0, 1,0,5,0);

        // reset state
        repeat (3) tick();
        check("reset spike_out", spike_out, 0);
        check("reset spike_total", spike_total, 0);
        check("reset sat_flag", sat_flag, 0);
        check("reset ready", sif.sample_ready, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        threshold = 16'd10;
        #1;
        check("ready after release", sif.sample_ready, 1);

        foreach (tv[i]) begin
            clear            = tv[i].clr;
            leak_shift       = tv[i].lk;
            sif.sample_valid = tv[i].vld;
            sif.sample_x     = tv[i].x;
            sif.sample_y     = tv[i].y;
            #1;
            check($sformatf("vec%0d ready", i), sif.sample_ready, tv[i].rdy);
            tick();
            check($sformatf("vec%0d spike_out", i), spike_out, tv[i].spk);
            check($sformatf("vec%0d spike_total", i), spike_total, tv[i].tot);
            check($sformatf("vec%0d sat_flag", i), sat_flag, tv[i].sat);
        end
        clear = 1'b0;
        leak_shift = 4'd0;
        sif.sample_valid = 1'b0;

        // saturation: 16 x 32767 = 524272 fits, the 17th clamps
        threshold = 16'd0;
        sif.sample_x = 16'sd32767;
        sif.sample_y = 16'sd0;
        for (int k = 1; k <= 20; k++) begin
            sif.sample_valid = 1'b1;
            tick();
            if (k == 16) check("sat before clamp", sat_flag, 0);
            if (k == 17) check("sat at clamp", sat_flag, 1);
        end
        sif.sample_valid = 1'b0;
        repeat (4) tick();
        check("sat sticky", sat_flag, 1);
        check("no spikes at T=0", spike_total, 5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat cleared", sat_flag, 0);
        threshold = 16'd10;
        sif.sample_x = 16'sd9;
        sif.sample_valid = 1'b1;
        tick();
        sif.sample_valid = 1'b0;
        repeat (4) tick();
        check("membrane zero after clear", spike_total, 5);

        // back-pressure: T=1, x=100 every cycle until pending saturates
        clear = 1'b1;
        tick();
        clear = 1'b0;
        threshold = 16'd1;
        sif.sample_x = 16'sd100;
        sif.sample_y = 16'sd0;
        rises = 0; other_hi = 0; last_rise = -1; min_int = 1000; max_int = 0;
        base_total = spike_total;
        acc = 0;
        got_full = 1'b0;
        for (int k = 0; k < 100 && !got_full; k++) begin
            sif.sample_valid = 1'b1;
            #1;
            if (sif.sample_ready) begin
                acc++;
                tick();
            end else begin
                got_full = 1'b1;
            end
        end
        check("ready dropped", got_full, 1);
        check("accepted before full", acc, 20);
        sif.sample_valid = 1'b0;
        repeat (120) tick();
        check("pulses == accepted", rises, acc);
        diff = spike_total - base_total;
        check("spike_total delta", diff, acc);
        check("min pulse period", min_int, 4);
        check("max pulse period", max_int, 4);
        check("other lines quiet", other_hi, 0);
        check("ready after drain", sif.sample_ready, 1);

        // asynchronous reset in the middle of a HIGH pulse
        threshold = 16'd10;
        sif.sample_x = 16'sd10;
        sif.sample_valid = 1'b1;
        tick();
        sif.sample_valid = 1'b0;
        tick();
        check("pulse high before reset", spike_out, 1);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("async reset spike_out", spike_out, 0);
        check("async reset spike_total", spike_total, 0);
        check("async reset ready", sif.sample_ready, 0);
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        #1;
        check("ready after second reset", sif.sample_ready, 1);
        sif.sample_x = 16'sd9;
        sif.sample_valid = 1'b1;
        tick();
        sif.sample_valid = 1'b0;
        repeat (4) tick();
        check("membrane reset", spike_total, 0);
        check("no resumed pulse", spike_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
